polarity_sync_rx: RTL and testbench
===================================

// Module: polarity_sync_rx
// PURPOSE
//   Receive end of a single-wire serial link whose data path passes an unknown number of
//   inverter stages. Hunts for SYNC_WORD or its complement, locks the line polarity, and
//   de-inverts the payload. Delivers parallel payload words with a valid pulse.
//   Flywheels through isolated sync errors.
// PARAMETERS
//   SYNC_W     8      sync word width, bits
//   SYNC_WORD  8'hA7  sync pattern, MSB first; must not be bit-periodic
//   FRAME_LEN  16     payload bits per frame, sent after each sync word
//   LOSS_CNT   3      consecutive bad syncs that force unlock, range 1..7
// PORTS
//   C      in   1          clock, rising edge
//   RN     in   1          asynchronous active-low reset
//   EN     in   1          bit strobe; D is sampled only in cycles with EN=1
//   D      in   1          serial line data, possibly inverted
//   Q      out  FRAME_LEN  last payload word, polarity-corrected, first bit received = MSB
//   QV     out  1          one-cycle pulse: Q was updated
//   INV    out  1          1 = line polarity is inverted
//   LOCK   out  1          1 = sync confirmed on two consecutive sync boundaries
//   ERR    out  1          one-cycle pulse: bad sync at an expected boundary
// BEHAVIOUR
//   Reset
//     RN low clears all state asynchronously: Q=0, QV=0, INV=0, LOCK=0, ERR=0,
//     state=HUNT, counters=0.
//   Shift register
//     SR (SYNC_W bits) shifts D in at the LSB on every EN=1 cycle, in every state.
//     With EN=0, no state or counter changes; QV and ERR return to 0.
//   HUNT
//     Match test uses the post-shift SR on each EN cycle.
//     SR==SYNC_WORD  -> INV<=0, go to PAYLOAD.
//     SR==~SYNC_WORD -> INV<=1, go to PAYLOAD.
//     No match       -> stay in HUNT.
//     Entering PAYLOAD clears bit_cnt.
//   PAYLOAD
//     Each EN shifts (D^INV) into the payload shift register and increments bit_cnt.
//     On the EN cycle of bit FRAME_LEN: Q<=payload, QV=1 in the following cycle,
//     go to CHECK, bit_cnt<=0.
//     Frames are delivered whether or not LOCK is set.
//   CHECK
//     Collect SYNC_W bits. On the last bit, compare SR with SYNC_WORD^{SYNC_W{INV}}.
//     Match: LOCK<=1, miss<=0, go to PAYLOAD.
//     Mismatch, including a complement match: ERR pulse, miss<=miss+1.
//       If miss+1==LOSS_CNT: LOCK<=0, INV<=0, miss<=0, go to HUNT.
//       Otherwise keep INV and go to PAYLOAD (flywheel).
//   Latency
//     QV and ERR assert one C cycle after the EN cycle that carries the deciding bit.
//   Simultaneous events
//     RN low has priority over everything.
//     A sync match and reaching LOSS_CNT cannot occur together (exclusive branches).
//   Reset mid-frame discards the partial frame; no QV is issued for it.
// CONFIGURATION
//   POLARITY_RX_STATS_EN defined:
//     Adds out ports FRM_CNT[15:0] and ERR_CNT[15:0], both saturating at 16'hFFFF,
//     cleared by RN.
//     FRM_CNT increments on every QV. ERR_CNT increments on every ERR.
//   Not defined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   Package polarity_rx_pkg holds:
//     state enum {HUNT, PAYLOAD, CHECK} (2 bits)
//     default SYNC_WORD constant
//     STATS_W=16 constant
//   Sub-module sync_match (combinational): inputs sr, pattern; outputs match, match_inv.
//     Used by HUNT and CHECK.
// TESTING
//   1. Non-inverted stream: 8'hA7, 16'h1234, 8'hA7
//      -> QV once with Q=16'h1234, INV=0; LOCK=1 after second sync.
//   2. Inverted stream: 8'h58, 16'hEDCB, 8'h58
//      -> Q=16'h1234, INV=1, LOCK=1.
//   3. Locked, then one corrupted sync 8'hA6
//      -> one ERR pulse, LOCK stays 1; next frame is still delivered.
//   4. Locked, then 3 consecutive bad syncs
//      -> 3 ERR pulses, then LOCK=0, INV=0, state HUNT; no QV until a new sync.
//   5. EN toggling 1-in-4 cycles during test 1
//      -> identical Q/INV/LOCK; QV is exactly 1 cycle wide.
//   6. RN pulsed low at payload bit 9
//      -> all outputs 0 immediately; no QV for that frame; re-hunt succeeds on the next sync.

Source files
------------

// File: rtl/polarity_rx_pkg.sv
// Shared types and constants for the polarity-locking serial receiver.
package polarity_rx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;

  localparam logic [7:0]  DEF_SYNC_WORD = 8'hA7;
  localparam int unsigned STATS_W       = 16;
  localparam int unsigned MISS_W        = 3;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/sync_match.sv
// Combinational sync comparator: exact match and complement match against a pattern.
module sync_match #(
  parameter int unsigned SYNC_W = 8
) (
  input  logic [SYNC_W-1:0] sr,
  input  logic [SYNC_W-1:0] pattern,
  output logic              match,
  output logic              match_inv
);

  assign match     = (sr == pattern);
  assign match_inv = (sr == ~pattern);

endmodule

// File: rtl/polarity_sync_rx.sv
// Serial receiver that hunts for a sync word of either polarity, locks, and de-inverts payload.
// Optional frame/error statistics counters are enabled with POLARITY_RX_STATS_EN.
module polarity_sync_rx
  import polarity_rx_pkg::*;
#(
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD),
  parameter int unsigned       FRAME_LEN = 16,
  parameter int unsigned       LOSS_CNT  = 3
) (
  input  logic                 C,
  input  logic                 RN,
  input  logic                 EN,
  input  logic                 D,
  output logic [FRAME_LEN-1:0] Q,
  output logic                 QV,
  output logic                 INV,
  output logic                 LOCK,
  output logic                 ERR
`ifdef POLARITY_RX_STATS_EN
  ,
  output logic [STATS_W-1:0]   FRM_CNT,
  output logic [STATS_W-1:0]   ERR_CNT
`endif
);

  localparam int unsigned MAX_LEN = (FRAME_LEN > SYNC_W) ? FRAME_LEN : SYNC_W;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  state_e                 state_q, state_d;
  // Only SYNC_W-1 history bits are stored; the incoming bit completes the window.
  logic [SYNC_W-2:0]      sr_q, sr_d;
  logic [FRAME_LEN-2:0]   pay_q, pay_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  logic [FRAME_LEN-1:0]   q_q, q_d;
  logic                   qv_q, qv_d;
  logic                   inv_q, inv_d;
  logic                   lock_q, lock_d;
  logic                   err_q, err_d;

  logic [SYNC_W-1:0]      sr_full;
  logic [FRAME_LEN-1:0]   pay_full;
  logic [SYNC_W-1:0]      pattern;
  logic                   hit;
  logic                   hit_inv;
  logic [MISS_W-1:0]      miss_inc;
  logic [CNT_W-1:0]       cnt_inc;

  assign sr_full  = {sr_q, D};
  assign pay_full = {pay_q, D ^ inv_q};
  assign miss_inc = miss_q + MISS_W'(1);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // While locked the expected sync carries the locked polarity; hunting looks for both.
  assign pattern = (state_q == CHECK) ? (SYNC_WORD ^ {SYNC_W{inv_q}}) : SYNC_WORD;

  sync_match #(
    .SYNC_W (SYNC_W)
  ) u_sync_match (
    .sr        (sr_full),
    .pattern   (pattern),
    .match     (hit),
    .match_inv (hit_inv)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    inv_d   = inv_q;
    lock_d  = lock_q;
    err_d   = 1'b0;

    if (EN) begin
      sr_d = sr_full[SYNC_W-2:0];
      unique case (state_q)
        HUNT: begin
          if (hit) begin
            inv_d   = 1'b0;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else if (hit_inv) begin
            inv_d   = 1'b1;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pay_d = pay_full[FRAME_LEN-2:0];
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            q_d     = pay_full;
            qv_d    = 1'b1;
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        CHECK: begin
          if (cnt_q == CNT_W'(SYNC_W - 1)) begin
            cnt_d = '0;
            if (hit) begin
              lock_d  = 1'b1;
              miss_d  = '0;
              state_d = PAYLOAD;
            end else begin
              err_d = 1'b1;
              if (miss_inc == MISS_W'(LOSS_CNT)) begin
                lock_d  = 1'b0;
                inv_d   = 1'b0;
                miss_d  = '0;
                state_d = HUNT;
              end else begin
                miss_d  = miss_inc;
                state_d = PAYLOAD;
              end
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q <= HUNT;
      sr_q    <= '0;
      pay_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      inv_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      inv_q   <= inv_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign Q    = q_q;
  assign QV   = qv_q;
  assign INV  = inv_q;
  assign LOCK = lock_q;
  assign ERR  = err_q;

`ifdef POLARITY_RX_STATS_EN
  logic [STATS_W-1:0] frm_cnt_q;
  logic [STATS_W-1:0] err_cnt_q;

  // Counters advance on the same edge that raises QV / ERR.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (qv_d) begin
        frm_cnt_q <= sat_inc(frm_cnt_q);
      end
      if (err_d) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  assign FRM_CNT = frm_cnt_q;
  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_polarity_sync_rx.sv
// Scoreboard bench: a stream-level reference model predicts QV/ERR events before driving.
module tb_polarity_sync_rx;

  localparam logic [7:0] SYNC = 8'hA7;
  localparam int         LOSS = 3;

  typedef struct {
    bit          is_err;
    logic [15:0] q;
    bit          inv;
    bit          lock;
  } ev_t;

  logic        clk;
  logic        rn;
  logic        en;
  logic        d;
  logic [15:0] q;
  logic        qv;
  logic        inv;
  logic        lock;
  logic        err;

  int n_checks;
  int n_fail;

  ev_t         exp_q[$];
  bit          stream[$];
  bit          m_inv;
  bit          m_lock;
  logic [15:0] m_q;
  bit          qv_prev;

  polarity_sync_rx dut (
    .C    (clk),
    .RN   (rn),
    .EN   (en),
    .D    (d),
    .Q    (q),
    .QV   (qv),
    .INV  (inv),
    .LOCK (lock),
    .ERR  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every QV/ERR pulse is matched against the next predicted event.
  always @(negedge clk) begin
    if (rn) begin
      if (qv && qv_prev) chk("qv_width", 32'd2, 32'd1);
      if (qv || err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, qv, err}, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, qv, err}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) chk("q", {16'd0, q}, {16'd0, e.q});
          chk("ev_inv", {31'd0, inv}, {31'd0, e.inv});
          chk("ev_lock", {31'd0, lock}, {31'd0, e.lock});
        end
      end
      qv_prev = qv;
    end else begin
      qv_prev = 1'b0;
    end
  end

  function automatic logic [7:0] win(input int k);
    logic [7:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      int idx;
      idx = k - 7 + j;
      w = {w[6:0], (idx < 0) ? 1'b0 : stream[idx]};
    end
    return w;
  endfunction

  // Walks the whole stream frame by frame: hunt, payload, sync check, flywheel/loss.
  task automatic model_run();
    int          pos;
    int          n;
    int          miss;
    bit          hunting;
    bit          found;
    bit          inv_m;
    bit          lock_m;
    logic [7:0]  w;
    logic [15:0] pl;
    pos = 0;
    n = stream.size();
    miss = 0;
    hunting = 1'b1;
    inv_m = 1'b0;
    lock_m = 1'b0;
    forever begin
      if (hunting) begin
        found = 1'b0;
        while (pos < n && !found) begin
          w = win(pos);
          if (w == SYNC) begin
            inv_m = 1'b0;
            found = 1'b1;
          end else if (w == ~SYNC) begin
            inv_m = 1'b1;
            found = 1'b1;
          end
          pos++;
        end
        if (!found) break;
        hunting = 1'b0;
      end
      if (pos + 16 > n) break;
      pl = '0;
      for (int j = 0; j < 16; j++) pl = {pl[14:0], stream[pos + j] ^ inv_m};
      pos += 16;
      m_q = pl;
      exp_q.push_back(ev_t'{is_err: 1'b0, q: pl, inv: inv_m, lock: lock_m});
      if (pos + 8 > n) break;
      w = win(pos + 7);
      pos += 8;
      if (w == (SYNC ^ {8{inv_m}})) begin
        lock_m = 1'b1;
        miss = 0;
      end else begin
        miss++;
        if (miss == LOSS) begin
          lock_m = 1'b0;
          inv_m = 1'b0;
          miss = 0;
          hunting = 1'b1;
        end
        exp_q.push_back(ev_t'{is_err: 1'b1, q: 16'd0, inv: inv_m, lock: lock_m});
      end
    end
    m_inv = inv_m;
    m_lock = lock_m;
  endtask

  task automatic push_word(input logic [31:0] w, input int width);
    for (int i = width - 1; i >= 0; i--) stream.push_back(w[i]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rn = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rn = 1'b1;
    m_q = '0;
    m_inv = 1'b0;
    m_lock = 1'b0;
  endtask

  // max_gap < 0 selects a fixed one-in-four EN pattern.
  task automatic drive(input int max_gap);
    foreach (stream[i]) begin
      int gap;
      gap = (max_gap < 0) ? 3 : $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        en = 1'b0;
        d = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      en = 1'b1;
      d = stream[i];
    end
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic run_phase(input string name, input int max_gap);
    model_run();
    drive(max_gap);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    chk({name, "_inv"}, {31'd0, inv}, {31'd0, m_inv});
    chk({name, "_lock"}, {31'd0, lock}, {31'd0, m_lock});
    chk({name, "_q"}, {16'd0, q}, {16'd0, m_q});
    exp_q.delete();
    stream.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    qv_prev = 1'b0;
    rn = 1'b1;
    en = 1'b0;
    d = 1'b0;
    m_q = '0;
    #2;
    rn = 1'b0;
    @(negedge clk);
    chk("reset_q", {16'd0, q}, 32'd0);
    chk("reset_qv", {31'd0, qv}, 32'd0);
    chk("reset_inv", {31'd0, inv}, 32'd0);
    chk("reset_lock", {31'd0, lock}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);

    // Normal polarity
    do_reset();
    push_word(32'hA7, 8); push_word(32'h1234, 16); push_word(32'hA7, 8);
    run_phase("t1", 0);

    // Inverted line
    do_reset();
    push_word(32'h58, 8); push_word(32'hEDCB, 16); push_word(32'h58, 8);
    run_phase("t2", 0);

    // Single corrupted sync while locked
    do_reset();
    push_word(32'hA7, 8); push_word(32'h1111, 16); push_word(32'hA7, 8);
    push_word(32'h2222, 16); push_word(32'hA6, 8); push_word(32'h3333, 16);
    push_word(32'hA7, 8); push_word(32'h4444, 16);
    run_phase("t3", 0);

    // Three consecutive bad syncs (one of them the complement) force unlock
    do_reset();
    push_word(32'hA7, 8); push_word(32'h0F0F, 16); push_word(32'hA7, 8);
    push_word(32'h1357, 16); push_word(32'hA6, 8); push_word(32'h2468, 16);
    push_word(32'h58, 8); push_word(32'h9BDF, 16); push_word(32'h00, 8);
    push_word(32'h0, 32);
    run_phase("t4", 0);

    // Sparse bit strobe
    do_reset();
    push_word(32'hA7, 8); push_word(32'h1234, 16); push_word(32'hA7, 8);
    run_phase("t5", -1);

    // Reset in the middle of a payload
    do_reset();
    push_word(32'hA7, 8); push_word(32'h1234, 16); push_word(32'hA7, 8);
    push_word(32'h1FF, 9);
    run_phase("t6a", 0);
    #3;
    rn = 1'b0;
    #1;
    chk("t6_rst_q", {16'd0, q}, 32'd0);
    chk("t6_rst_qv", {31'd0, qv}, 32'd0);
    chk("t6_rst_inv", {31'd0, inv}, 32'd0);
    chk("t6_rst_lock", {31'd0, lock}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rn = 1'b1;
    m_q = '0;
    m_inv = 1'b0;
    m_lock = 1'b0;
    push_word(32'h58, 8); push_word(32'h5432, 16); push_word(32'h58, 8);
    push_word(32'hABCD, 16);
    run_phase("t6b", 0);

    // Randomized streams: noise, random polarity, occasional corrupted syncs
    for (int it = 0; it < 8; it++) begin
      logic [7:0] sw;
      int nf;
      do_reset();
      push_word($urandom, $urandom_range(0, 20));
      sw = ($urandom_range(0, 1) == 1) ? ~SYNC : SYNC;
      push_word({24'd0, sw}, 8);
      nf = $urandom_range(3, 7);
      for (int f = 0; f < nf; f++) begin
        push_word($urandom, 16);
        if ($urandom_range(0, 3) == 0) push_word($urandom, 8);
        else push_word({24'd0, sw}, 8);
      end
      push_word($urandom, $urandom_range(0, 12));
      run_phase("rand", $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
